nonrestoring_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 24 ++
 rtl/divider_control_unit.sv | 71 +++++++
 rtl/nonrestoring_divider.sv | 99 +++++++++
 tb/tb_nonrestoring_divider.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding, default
// operand width and the bit positions of the control strobes.
package divider_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        ITER    = 3'd3,
        CORRECT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int S_LOAD      = 0;
    localparam int S_CHECK     = 1;
    localparam int S_SHIFT_SUB = 2;
    localparam int S_SHIFT_ADD = 3;
    localparam int S_CORRECT   = 4;
    localparam int S_OUT       = 5;
    localparam int NUM_STROBES = 6;

endpackage

// File: rtl/divider_control_unit.sv
// Sequencer for the non-restoring divider: walks LOAD/CHECK/ITER/CORRECT/DONE
// and emits one-hot strobes that steer the datapath in the top level.
module divider_control_unit
    import divider_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic bgn,
    input  logic a_sign,
    input  logic m_zero,
    input  logic last_iter,
    output logic c_load,
    output logic c_check,
    output logic c_shift_sub,
    output logic c_shift_add,
    output logic c_correct,
    output logic c_out,
    output logic done,
    output logic busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_STROBES-1:0] strobe;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        strobe    = '0;
        case (state)
            IDLE:    if (bgn) state_nxt = LOAD;
            LOAD: begin
                strobe[S_LOAD] = 1'b1;
                state_nxt      = CHECK;
            end
            CHECK: begin
                strobe[S_CHECK] = 1'b1;
                state_nxt       = m_zero ? DONE : ITER;
            end
            ITER: begin
                // the sign of the current partial remainder picks add vs subtract
                if (a_sign) strobe[S_SHIFT_ADD] = 1'b1;
                else        strobe[S_SHIFT_SUB] = 1'b1;
                if (last_iter) state_nxt = CORRECT;
            end
            CORRECT: begin
                strobe[S_CORRECT] = 1'b1;
                state_nxt         = DONE;
            end
            DONE: begin
                strobe[S_OUT] = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign c_load      = strobe[S_LOAD];
    assign c_check     = strobe[S_CHECK];
    assign c_shift_sub = strobe[S_SHIFT_SUB];
    assign c_shift_add = strobe[S_SHIFT_ADD];
    assign c_correct   = strobe[S_CORRECT];
    assign c_out       = strobe[S_OUT];
    assign done        = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned sequential divider, one quotient bit per clock (non-restoring).
// Holds the A/Q/M datapath and the registered results; sequencing lives in the control unit.
module nonrestoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   m;
    logic [CNT_W-1:0] cnt;

    logic c_load, c_check, c_shift_sub, c_shift_add, c_correct, c_out;
    logic a_sign, m_zero, last_iter;

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] a_nxt;
    logic [WIDTH:0] a_fix;

    assign a_sign    = a[WIDTH];
    assign m_zero    = (m == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // arithmetic is WIDTH+1 bits and wraps, so the sign bit falls out naturally
    assign a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
    assign a_nxt = c_shift_add ? (a_sh + m) : (a_sh - m);
    assign a_fix = a_sign ? (a + m) : a;

    divider_control_unit u_ctrl (
        .clk         (clk),
        .rst_b       (rst_b),
        .bgn         (bgn),
        .a_sign      (a_sign),
        .m_zero      (m_zero),
        .last_iter   (last_iter),
        .c_load      (c_load),
        .c_check     (c_check),
        .c_shift_sub (c_shift_sub),
        .c_shift_add (c_shift_add),
        .c_correct   (c_correct),
        .c_out       (c_out),
        .done        (done),
        .busy        (busy)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            cnt <= '0;
        end else if (c_load) begin
            a   <= '0;
            q   <= dividend;
            m   <= {1'b0, divisor};
            cnt <= '0;
        end else if (c_shift_sub || c_shift_add) begin
            a   <= a_nxt;
            q   <= {q[WIDTH-2:0], ~a_nxt[WIDTH]};
            cnt <= cnt + 1'b1;
        end else if (c_correct) begin
            a <= a_fix;
        end else if (c_out) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (c_load) begin
            div_by_zero <= 1'b0;
        end else if (c_check && m_zero) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= q;
        end else if (c_correct) begin
            quotient    <= q;
            remainder   <= a_fix[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider: 8-bit and 16-bit instances,
// directed boundary/latency/reset/handshake scenarios plus a random sweep.
module tb_nonrestoring_divider;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        bgn = 1'b0;
    logic [7:0]  dividend = '0, divisor = '0, quotient, remainder;
    logic        busy, done, div_by_zero;

    logic        bgn16 = 1'b0;
    logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;
    logic        busy16, done16, dbz16;

    typedef struct { logic [15:0] q; logic [15:0] r; logic dbz; } exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nonrestoring_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst_b(rst_b), .bgn(bgn), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    nonrestoring_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_b(rst_b), .bgn(bgn16), .dividend(dividend16), .divisor(divisor16),
        .quotient(quotient16), .remainder(remainder16), .busy(busy16), .done(done16),
        .div_by_zero(dbz16)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ones);
        exp_t e;
        e.dbz = (b == 16'd0);
        e.q   = e.dbz ? ones : a / b;
        e.r   = e.dbz ? a : a % b;
        return e;
    endfunction

    // Drives one 8-bit operation, then pops its expectation when done shows up.
    // lat counts edges from the bgn-sampling edge to the done cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat, output bit busy_ok);
        exp_t e;
        sb.push_back(model({8'h0, a}, {8'h0, b}, 16'h00ff));
        @(negedge clk); dividend = a; divisor = b; bgn = 1'b1;
        @(negedge clk); bgn = 1'b0; lat = 1; busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        e = sb.pop_front();
        n_cmp++;
        if (done !== 1'b1 || quotient !== e.q[7:0] || remainder !== e.r[7:0] || div_by_zero !== e.dbz) begin
            n_fail++;
            $display("FAIL op8 %0d/%0d: got q=%0d r=%0d dbz=%b done=%b, want q=%0d r=%0d dbz=%b",
                     a, b, quotient, remainder, div_by_zero, done, e.q[7:0], e.r[7:0], e.dbz);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, output int lat);
        exp_t e;
        sb.push_back(model(a, b, 16'hffff));
        @(negedge clk); dividend16 = a; divisor16 = b; bgn16 = 1'b1;
        @(negedge clk); bgn16 = 1'b0; lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        n_cmp++;
        if (done16 !== 1'b1 || quotient16 !== e.q || remainder16 !== e.r || dbz16 !== e.dbz) begin
            n_fail++;
            $display("FAIL op16 %0d/%0d: got q=%0d r=%0d dbz=%b done=%b, want q=%0d r=%0d dbz=%b",
                     a, b, quotient16, remainder16, dbz16, done16, e.q, e.r, e.dbz);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
            quotient16 !== 16'd0 || remainder16 !== 16'd0 || busy16 !== 1'b0 || done16 !== 1'b0 || dbz16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; bit bok;
        op8(8'd100, 8'd7, lat, bok);
        n_cmp++;
        if (lat != 12 || !bok) begin
            n_fail++; $display("FAIL basic_latency: got lat=%0d busy_ok=%0b, want lat=12 busy_ok=1", lat, bok);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_boundaries();
        int lat; bit bok;
        op8(8'd5, 8'd9, lat, bok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (quotient !== 8'd0 || remainder !== 8'd5) begin
            n_fail++; $display("FAIL hold_5_9: got q=%0d r=%0d, want 0 5", quotient, remainder);
        end
        op8(8'd255, 8'd255, lat, bok);
        op8(8'd255, 8'd1, lat, bok);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (quotient !== 8'd255 || remainder !== 8'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL hold_255_1: got q=%0d r=%0d done=%b, want 255 0 0", quotient, remainder, done);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bok;
        op8(8'd42, 8'd0, lat, bok);
        n_cmp++;
        if (lat != 3) begin
            n_fail++; $display("FAIL dbz_latency: got %0d, want 3", lat);
        end
        op8(8'd42, 8'd6, lat, bok);
        n_cmp++;
        if (lat != 12 || div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL dbz_clear: got lat=%0d dbz=%b, want 12 0", lat, div_by_zero);
        end
    endtask

    task automatic test_mid_reset();
        int lat; bit bok;
        @(negedge clk); dividend = 8'd200; divisor = 8'd3; bgn = 1'b1;
        @(negedge clk); bgn = 1'b0;
        repeat (5) @(negedge clk);
        rst_b = 1'b0; #1;
        n_cmp++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                               quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk); rst_b = 1'b1;
        op8(8'd200, 8'd3, lat, bok);
        n_cmp++;
        if (lat != 12) begin
            n_fail++; $display("FAIL after_reset_latency: got %0d, want 12", lat);
        end
    endtask

    task automatic test_ignore_bgn();
        exp_t e; int lat;
        sb.push_back(model(16'd123, 16'd10, 16'h00ff));
        @(negedge clk); dividend = 8'd123; divisor = 8'd10; bgn = 1'b1;
        @(negedge clk); bgn = 1'b0; lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
            if (lat == 5) begin bgn = 1'b1; dividend = 8'd0; divisor = 8'd1; end
            if (lat == 6) bgn = 1'b0;
        end
        e = sb.pop_front();
        n_cmp++;
        if (done !== 1'b1 || lat != 12 || quotient !== e.q[7:0] || remainder !== e.r[7:0]) begin
            n_fail++; $display("FAIL ignore_bgn: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=12",
                               quotient, remainder, lat, e.q[7:0], e.r[7:0]);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_bgn_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int t; int t1; int t2;
        t1 = -1; t2 = -1;
        sb.push_back(model(16'd77, 16'd5, 16'h00ff));
        sb.push_back(model(16'd250, 16'd9, 16'h00ff));
        @(negedge clk); dividend = 8'd77; divisor = 8'd5; bgn = 1'b1;
        for (t = 1; t < 60 && t2 < 0; t++) begin
            @(negedge clk);
            if (t == 2) begin dividend = 8'd250; divisor = 8'd9; end
            if (done === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (quotient !== e.q[7:0] || remainder !== e.r[7:0]) begin
                    n_fail++; $display("FAIL b2b_result: got q=%0d r=%0d, want q=%0d r=%0d",
                                       quotient, remainder, e.q[7:0], e.r[7:0]);
                end
                if (t1 < 0) t1 = t; else t2 = t;
            end
        end
        bgn = 1'b0;
        n_cmp++;
        if (t2 - t1 != 13 || t1 != 12) begin
            n_fail++; $display("FAIL b2b_spacing: got first=%0d gap=%0d, want 12 13", t1, t2 - t1);
        end
        while (sb.size() > 0) void'(sb.pop_front());
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int lat; bit bok; int bad_lat;
        bad_lat = 0;
        for (int i = 0; i < 2000; i++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat, bok);
            if (lat != 12 && lat != 3) bad_lat++;
        end
        for (int i = 0; i < 500; i++) begin
            op16(16'($urandom_range(0, 65535)), (i % 50 == 0) ? 16'd0 : 16'($urandom_range(0, 65535)), lat);
            if (lat != 20 && lat != 3) bad_lat++;
        end
        op16(16'd65535, 16'd65535, lat);
        n_cmp++;
        if (bad_lat != 0) begin
            n_fail++; $display("FAIL random_latency: got %0d bad latencies, want 0", bad_lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_mid_reset();
        test_ignore_bgn();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
